// File: rtl/seg7_pkg.sv
// Shared definitions for the binary-to-BCD formatter and the 7-segment controller:
// special digit codes, converter state encoding and the leading-zero blanking rule.
package seg7_pkg;

    localparam logic [3:0] DIG_BLANK = 4'hB;
    localparam logic [3:0] DIG_DASH  = 4'hA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FMT   = 2'd2
    } state_t;

    // Blank digits 3..1 while they are zero with no decimal point; the first
    // nonzero digit or the first digit carrying a dp stops the scan.
    function automatic logic [15:0] blank_leading(input logic [15:0] digits,
                                                  input logic [3:0]  dp);
        logic [15:0] res;
        logic        scan;
        res  = digits;
        scan = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (scan && (digits[i*4 +: 4] == 4'h0) && !dp[i]) begin
                res[i*4 +: 4] = DIG_BLANK;
            end else begin
                scan = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dabble_step.sv
// One combinational double-dabble iteration: add 3 to every BCD nibble >= 5,
// then shift the whole {bcd, binary} scratch left by one bit.
module dabble_step #(
    parameter int BIN_W = 14
) (
    input  logic [16+BIN_W-1:0] din,
    output logic [16+BIN_W-1:0] dout
);

    logic [15:0] adj;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign adj[gi*4 +: 4] = (din[BIN_W+gi*4 +: 4] >= 4'd5)
                                  ? din[BIN_W+gi*4 +: 4] + 4'd3
                                  : din[BIN_W+gi*4 +: 4];
        end
    endgenerate

    assign dout = {adj, din[BIN_W-1:0]} << 1;

endmodule

// File: rtl/bin2bcd_fmt.sv
// Sequential binary-to-BCD converter (one dabble iteration per clock) with
// leading-zero blanking and overflow dashes, feeding the 4-digit display controller.
module bin2bcd_fmt
    import seg7_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic [3:0]       dp_in,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    output logic [15:0]      bcd,
    output logic [3:0]       bcd_dp
);

    localparam int               SW       = 16 + BIN_W;
    localparam int               CW       = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_VAL);
    localparam logic [CW-1:0]    LAST_CNT = CW'(BIN_W - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      dp_q, dp_d;
    logic            blank_q, blank_d;
    logic            ovfp_q, ovfp_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [3:0]      bcd_dp_q, bcd_dp_d;
    logic [SW-1:0]   step_out;
    logic [15:0]     digits;

    dabble_step #(.BIN_W(BIN_W)) u_step (
        .din  (scratch_q),
        .dout (step_out)
    );

    assign digits = scratch_q[SW-1:BIN_W];

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        dp_d      = dp_q;
        blank_d   = blank_q;
        ovfp_d    = ovfp_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        bcd_dp_d  = bcd_dp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dp_d    = dp_in;
                    blank_d = blank_lz;
                    if (bin > MAX_B) begin
                        ovfp_d  = 1'b1;
                        state_d = FMT;
                    end else begin
                        ovfp_d    = 1'b0;
                        scratch_d = {16'h0, bin};
                        cnt_d     = '0;
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                scratch_d = step_out;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FMT;
                end
            end
            FMT: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
                if (ovfp_q) begin
                    bcd_d    = {4{DIG_DASH}};
                    bcd_dp_d = 4'b0000;
                    ovf_d    = 1'b1;
                end else begin
                    ovf_d    = 1'b0;
                    bcd_dp_d = dp_q;
                    bcd_d    = blank_q ? blank_leading(digits, dp_q) : digits;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            dp_q      <= 4'b0000;
            blank_q   <= 1'b0;
            ovfp_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= {4{DIG_BLANK}};
            bcd_dp_q  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            dp_q      <= dp_d;
            blank_q   <= blank_d;
            ovfp_q    <= ovfp_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            bcd_dp_q  <= bcd_dp_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign bcd    = bcd_q;
    assign bcd_dp = bcd_dp_q;

endmodule

// File: tb/tb_bin2bcd_fmt.sv
// Directed-vector bench for bin2bcd_fmt: latency, blanking, overflow, busy
// handling, back-to-back starts and mid-conversion reset.
module tb_bin2bcd_fmt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic [3:0]  dp_in = 4'b0000;
    logic        blank_lz = 1'b0;
    logic        busy, done, valid, ovf;
    logic [15:0] bcd;
    logic [3:0]  bcd_dp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_fmt #(.BIN_W(14), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .ovf      (ovf),
        .bcd      (bcd),
        .bcd_dp   (bcd_dp)
    );

    // Present one start pulse; returns #1 after the accepting edge.
    task automatic pulse_start(input logic [13:0] v, input logic [3:0] dp, input logic blz);
        bin = v; dp_in = dp; blank_lz = blz; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (sampled #1 after each edge); -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, valid, ovf} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {busy, done, valid, ovf});
        end
        checks++;
        if (bcd !== 16'hBBBB || bcd_dp !== 4'b0000) begin
            failures++; $display("FAIL reset_out got bcd=%h dp=%b want BBBB/0000", bcd, bcd_dp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: bcd=%h valid=%b", bcd, valid);
    endtask

    task automatic test_basic;
        int lat;
        pulse_start(14'd1234, 4'b0000, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL basic_busy got=%b want=1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 15) begin
            failures++; $display("FAIL basic_latency got=%0d want=15", lat);
        end
        checks++;
        if (bcd !== 16'h1234 || bcd_dp !== 4'b0000 || ovf !== 1'b0 || valid !== 1'b1) begin
            failures++; $display("FAIL basic_result got bcd=%h dp=%b ovf=%b valid=%b want 1234/0000/0/1",
                                 bcd, bcd_dp, ovf, valid);
        end
        bin = 14'd77; dp_in = 4'b1111;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bcd !== 16'h1234 || bcd_dp !== 4'b0000) begin
            failures++; $display("FAIL basic_hold got bcd=%h dp=%b want 1234/0000", bcd, bcd_dp);
        end
        $display("basic: bin=1234 lat=%0d bcd=%h", lat, bcd);
    endtask

    task automatic test_blanking;
        logic [13:0] vin [6];
        logic [3:0]  vdp [6];
        logic        vbl [6];
        logic [15:0] vexp [6];
        int lat;
        vin[0] = 14'd7;    vdp[0] = 4'b0000; vbl[0] = 1'b1; vexp[0] = 16'hBBB7;
        vin[1] = 14'd7;    vdp[1] = 4'b0000; vbl[1] = 1'b0; vexp[1] = 16'h0007;
        vin[2] = 14'd5;    vdp[2] = 4'b0100; vbl[2] = 1'b1; vexp[2] = 16'hB005;
        vin[3] = 14'd0;    vdp[3] = 4'b0000; vbl[3] = 1'b1; vexp[3] = 16'hBBB0;
        vin[4] = 14'd9999; vdp[4] = 4'b0000; vbl[4] = 1'b1; vexp[4] = 16'h9999;
        vin[5] = 14'd305;  vdp[5] = 4'b0010; vbl[5] = 1'b1; vexp[5] = 16'hB305;
        for (int i = 0; i < 6; i++) begin
            pulse_start(vin[i], vdp[i], vbl[i]);
            wait_done(lat);
            checks++;
            if (lat !== 15 || bcd !== vexp[i] || bcd_dp !== vdp[i] || ovf !== 1'b0) begin
                failures++;
                $display("FAIL blank_%0d bin=%0d got lat=%0d bcd=%h dp=%b ovf=%b want 15/%h/%b/0",
                         i, vin[i], lat, bcd, bcd_dp, ovf, vexp[i], vdp[i]);
            end
            $display("blank: bin=%0d dp=%b blz=%b bcd=%h", vin[i], vdp[i], vbl[i], bcd);
        end
    endtask

    task automatic test_overflow;
        int lat;
        pulse_start(14'd10000, 4'b1111, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL ovf_latency got=%0d want=1", lat);
        end
        checks++;
        if (bcd !== 16'hAAAA || ovf !== 1'b1 || bcd_dp !== 4'b0000) begin
            failures++; $display("FAIL ovf_result got bcd=%h ovf=%b dp=%b want AAAA/1/0000", bcd, ovf, bcd_dp);
        end
        $display("ovf: bin=10000 lat=%0d bcd=%h ovf=%b", lat, bcd, ovf);
        pulse_start(14'd42, 4'b0000, 1'b1);
        wait_done(lat);
        checks++;
        if (bcd !== 16'hBB42 || ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_clear got bcd=%h ovf=%b want BB42/0", bcd, ovf);
        end
        $display("ovf: bin=42 bcd=%h ovf=%b", bcd, ovf);
    endtask

    task automatic test_back_to_back;
        int lat;
        pulse_start(14'd1234, 4'b0000, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        pulse_start(14'd42, 4'b0001, 1'b0);
        wait_done(lat);
        checks++;
        if (lat + 6 !== 15 || bcd !== 16'h1234 || bcd_dp !== 4'b0000) begin
            failures++; $display("FAIL busy_ignore got lat=%0d bcd=%h dp=%b want 15/1234/0000",
                                 lat + 6, bcd, bcd_dp);
        end
        $display("b2b: ignored start, bcd=%h", bcd);
        pulse_start(14'd56, 4'b0000, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 15 || bcd !== 16'hBB56) begin
            failures++; $display("FAIL done_cycle_start got lat=%0d bcd=%h want 15/BB56", lat, bcd);
        end
        $display("b2b: start in done cycle, bcd=%h", bcd);
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        pulse_start(14'd1234, 4'b0000, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd !== 16'hBBBB || valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            failures++; $display("FAIL midreset_out got bcd=%h valid=%b busy=%b ovf=%b want BBBB/0/0/0",
                                 bcd, valid, busy, ovf);
        end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || bcd !== 16'hBBBB || valid !== 1'b0) begin
            failures++; $display("FAIL midreset_nodone got dones=%0d bcd=%h valid=%b want 0/BBBB/0",
                                 seen, bcd, valid);
        end
        pulse_start(14'd88, 4'b0000, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 15 || bcd !== 16'hBB88 || valid !== 1'b1) begin
            failures++; $display("FAIL midreset_recover got lat=%0d bcd=%h valid=%b want 15/BB88/1",
                                 lat, bcd, valid);
        end
        $display("midreset: recovered bcd=%h", bcd);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_fmt.md
Name: bin2bcd_fmt

Overview:
- Sequential binary-to-BCD converter and formatter, directly upstream of the 4-digit 7-segment controller.
- Converts an unsigned binary value to four BCD digits using iterative double-dabble, one shift per clock.
- Formats the result for the display stage:
  - leading-zero blanking with code 4'hB (renders blank);
  - overflow indication with code 4'hA on all digits (renders dash).
- Outputs drive the controller's x / x_dp inputs; valid drives its en.

Parameters:
- BIN_W, 14, width of binary input; legal range 14..20 (must cover 9999).
- MAX_VAL, 9999, largest value displayed; any larger input is overflow.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; captured on the accepted start.
- dp_in  input  4  decimal-point mask; bit i = digit i; captured with bin.
- blank_lz  input  1  enable leading-zero blanking; captured with bin.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  single-cycle pulse when bcd/bcd_dp/ovf update.
- valid  output  1  high from the first done until reset.
- ovf  output  1  last result was overflow (bin > MAX_VAL).
- bcd  output  16  four digit codes; [3:0] = digit0 (rightmost).
- bcd_dp  output  4  registered decimal-point mask aligned with bcd.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; busy = 0, done = 0, valid = 0, ovf = 0;
  - bcd = 16'hBBBB (all blank), bcd_dp = 4'b0000;
  - internal scratch registers cleared.
- States: IDLE, SHIFT, FMT.
- IDLE:
  - start = 1 at edge E0 latches bin, dp_in, blank_lz.
  - If bin > MAX_VAL: set ovf_pending, go to FMT.
  - Else: load scratch = {16'h0, bin}, shift count = 0, go to SHIFT.
- SHIFT, one edge per iteration:
  - each BCD nibble in scratch >= 5 gets +3;
  - then scratch shifts left 1 (binary MSB enters the BCD LSB);
  - count increments; after BIN_W shifts (edge E_BIN_W), go to FMT.
- FMT, one edge:
  - Overflow case: bcd = 16'hAAAA, bcd_dp = 4'b0000, ovf = 1.
  - Normal case: ovf = 0, bcd_dp = latched dp_in.
  - Blanking when blank_lz = 1:
    - scan digits 3 down to 1;
    - replace a digit with 4'hB while it is 0 and its dp bit is 0;
    - stop at the first nonzero digit or the first digit whose dp bit is set;
    - digit0 is never blanked.
  - done = 1 for exactly this cycle; valid = 1; return to IDLE.
- Latency, measured as edges from the start-sampling edge to the done-visible edge:
  - normal: BIN_W+1 (15 by default);
  - overflow: 1.
- start while busy = 1 is ignored: no queueing, latched inputs unchanged.
- Back-to-back operation: start may be asserted in the cycle done is high (state is IDLE); it is accepted.
- Input stability: bin, dp_in and blank_lz may change freely after the accepting edge.
- Output stability: bcd, bcd_dp and ovf hold their value between done pulses.
- Reset mid-conversion: no done pulse is produced, and outputs return to their reset values.
- Width rules:
  - scratch register is 16 + BIN_W bits;
  - compare against MAX_VAL uses BIN_W-bit unsigned arithmetic;
  - count is $clog2(BIN_W+1) bits.

Decomposition:
- Package seg7_pkg:
  - DIG_BLANK = 4'hB, DIG_DASH = 4'hA;
  - bin2bcd state_t enum (IDLE/SHIFT/FMT, 2 bits);
  - shared with seg7_ctrl.
- One natural sub-module: dabble_step.
  - Combinational single iteration (add-3 on four nibbles, then shift).
  - Separately unit-testable; otherwise the block is flat.

Test Plan:
- bin=1234, dp_in=0, blank_lz=1, start pulse -> done exactly 15 cycles later; bcd=16'h1234, bcd_dp=0, ovf=0, valid=1.
- bin=7, blank_lz=1 -> bcd=16'hBBB7; then bin=7, blank_lz=0 -> bcd=16'h0007.
- bin=5, dp_in=4'b0100, blank_lz=1 -> bcd=16'hB005, bcd_dp=4'b0100.
- bin=0 -> 16'hBBB0; bin=9999 -> 16'h9999; bin=10000 -> bcd=16'hAAAA, ovf=1, done 1 cycle after start.
- start re-pulsed at cycle 5 of a busy conversion (bin changed to 42) -> ignored, result still 16'h1234; start in the done cycle -> accepted.
- rst_n low at cycle 8 of a conversion -> bcd=16'hBBBB, valid=0, busy=0, no done pulse; a new conversion after release completes normally.
